// File: rtl/regfile_scoreboard_if.sv
// Read, writeback and issue signals of the register file with its busy scoreboard.
// The master modport drives addresses and writes. The slave modport returns read data and busy flags.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              set_busy;
    logic [ADDR_W-1:0] set_addr;
    logic              any_busy;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, set_busy, set_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, any_busy
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, set_busy, set_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, any_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and write-to-read bypass.
// A per-register busy scoreboard is set at issue and cleared at writeback.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  rf
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam bit zeroEn   = (ZERO_REG != 0);

    logic [DATA_W-1:0]   regMem [NUM_REGS];
    logic [NUM_REGS-1:0] busyQ;
    logic [NUM_REGS-1:0] busyNext;
    logic                writeOk;
    logic                setOk;
    logic                zeroHit1;
    logic                zeroHit2;
    logic                wrHit1;
    logic                wrHit2;

    assign writeOk = rf.wr_en && !(zeroEn && (rf.wr_addr == '0));
    assign setOk   = rf.set_busy && !(zeroEn && (rf.set_addr == '0));

    // The bypass is gated by rst_n so the read ports return 0 for the whole time reset is held.
    assign zeroHit1 = zeroEn && (rf.rd_addr1 == '0);
    assign zeroHit2 = zeroEn && (rf.rd_addr2 == '0);
    assign wrHit1   = rst_n && rf.wr_en && (rf.wr_addr == rf.rd_addr1);
    assign wrHit2   = rst_n && rf.wr_en && (rf.wr_addr == rf.rd_addr2);

    always_comb begin
        busyNext = busyQ;
        if (rf.wr_en) begin
            busyNext[rf.wr_addr] = 1'b0;
        end
        // Set is applied after clear: a new producer issued while the old one retires keeps the bit busy.
        if (setOk) begin
            busyNext[rf.set_addr] = 1'b1;
        end
        if (zeroEn) begin
            busyNext[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regMem[i] <= '0;
            end
            busyQ <= '0;
        end else begin
            if (writeOk) begin
                regMem[rf.wr_addr] <= rf.wr_data;
            end
            busyQ <= busyNext;
        end
    end

    always_comb begin
        rf.rd_data1 = regMem[rf.rd_addr1];
        if (zeroHit1) begin
            rf.rd_data1 = '0;
        end else if (wrHit1) begin
            rf.rd_data1 = rf.wr_data;
        end
    end

    always_comb begin
        rf.rd_data2 = regMem[rf.rd_addr2];
        if (zeroHit2) begin
            rf.rd_data2 = '0;
        end else if (wrHit2) begin
            rf.rd_data2 = rf.wr_data;
        end
    end

    assign rf.rd_busy1 = busyQ[rf.rd_addr1] && !wrHit1;
    assign rf.rd_busy2 = busyQ[rf.rd_addr2] && !wrHit2;
    assign rf.any_busy = |busyQ;
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the single-cycle core and its pipelined follow-on.
- Two combinational read ports and one synchronous write port.
- Optional hardwired-zero register 0.
- Write-to-read bypass, so a value written in a cycle is visible to reads in that same cycle.
- Per-register busy scoreboard: the issue logic marks a destination pending and writeback clears it. Hazard and stall logic reads the busy flags.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never marked busy

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data (combinational)
- rd_data2  output  DATA_W  read port 2 data (combinational)
- rd_busy1  output  1  register at rd_addr1 has a write pending
- rd_busy2  output  1  register at rd_addr2 has a write pending
- wr_en  input  1  write enable (writeback)
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- set_busy  input  1  mark a destination register pending (issue)
- set_addr  input  ADDR_W  destination register to mark
- any_busy  output  1  OR of all busy bits (drain or flush indicator)

Behaviour:
- Reset: rst_n low asynchronously clears all NUM_REGS data entries to 0 and all busy bits to 0. While rst_n is low:
  - rd_data1/2 = 0
  - rd_busy1/2 = 0
  - any_busy = 0
  - Writes and set_busy are ignored.
  - Deassertion takes effect at the next rising edge.
- Write: on a rising clk with wr_en=1, entry[wr_addr] <= wr_data. With ZERO_REG=1 and wr_addr=0 the write is dropped.
- Read: rd_dataN = entry[rd_addrN] combinationally, with these overrides:
  - ZERO_REG=1 and rd_addrN=0: output 0.
  - Otherwise, if wr_en=1 and wr_addr==rd_addrN: output wr_data (same-cycle bypass). With ZERO_REG=1 this bypass never applies to address 0.
- Busy scoreboard: one bit per register, updated on the rising clk.
  - wr_en=1 clears busy[wr_addr].
  - set_busy=1 sets busy[set_addr].
  - Same address, both asserted in one cycle: set wins, so busy ends at 1 (a new producer was issued as the old one retired).
  - Different addresses: both updates apply.
  - ZERO_REG=1: busy[0] is constant 0; set_busy to address 0 is ignored.
  - Setting an already-busy bit leaves it at 1. Clearing a non-busy bit leaves it at 0.
- Busy read: rd_busyN = busy[rd_addrN] AND NOT(wr_en and wr_addr==rd_addrN).
  - A register retiring this cycle reads not-busy because its value is bypassed.
  - set_busy does not affect rd_busyN until the following cycle.
- any_busy is the registered OR of the busy bits, with no bypass.
- Both read ports are independent; rd_addr1 == rd_addr2 is legal and returns identical data and busy.
- Latency: data write and busy update take 1 cycle to reach storage. Reads and bypass have 0 cycles of latency.
- No X propagation: every entry is defined from reset onward.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle -> rd_data1 for r5 is 0 immediately, without waiting for a clock edge; any_busy=0.
- Write/read and bypass: wr_en=1, wr_addr=7, wr_data=0x12345678 with rd_addr1=7 in the same cycle -> rd_data1=0x12345678 before the edge. After the edge with wr_en=0 -> rd_data1 still 0x12345678.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and set_busy to r0 -> rd_data1 (addr 0)=0, rd_busy1=0, any_busy=0. With ZERO_REG=0, the same stimulus returns 0xFFFFFFFF.
- Scoreboard lifecycle: set_busy r3 -> next cycle rd_busy2(r3)=1 and any_busy=1. Writeback r3=0xA5 -> rd_busy2=0 and rd_data2=0xA5 that cycle. After the edge -> busy[3]=0 and any_busy=0.
- Simultaneous set and clear: busy[9]=1, then in one cycle wr_en to r9 with data 0x55 and set_busy r9 -> after the edge busy[9]=1 and entry[9]=0x55. Set and clear on different registers (r4 clear, r6 set) -> r4=0, r6=1.
- Parameter sweep: DATA_W=64, ADDR_W=3 -> write and read back 0x0123456789ABCDEF at r7; wr_addr wraps within 8 entries and no adjacent entry is corrupted.
